// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - round-robin arbiter sharing one I2C transaction engine among requesters
// Latches the winner's fields, launches the engine, retries on NACK, enforces timeout and bus gap.
module i2c_bus_arbiter #(
  parameter int N_REQ          = 2,
  parameter int GAP_CYCLES     = 1000,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 250000
) (
  input  logic                 CLK_50,
  input  logic                 RESET_N,
  input  logic [N_REQ-1:0]     REQ,
  input  logic [N_REQ-1:0]     REQ_RW,
  input  logic [8*N_REQ-1:0]   REQ_SLAVE_ADDR,
  input  logic [8*N_REQ-1:0]   REQ_POINTER,
  input  logic [16*N_REQ-1:0]  REQ_WDATA,
  output logic [N_REQ-1:0]     GNT,
  output logic [N_REQ-1:0]     REQ_DONE,
  output logic                 REQ_ERR,
  output logic [15:0]          RDATA,
  output logic                 ENG_GO,
  output logic                 ENG_RW,
  output logic [7:0]           ENG_SLAVE_ADDR,
  output logic [7:0]           ENG_POINTER,
  output logic [15:0]          ENG_WDATA,
  input  logic                 ENG_END,
  input  logic                 ENG_ACK_OK,
  input  logic [15:0]          ENG_RDATA,
  output logic                 BUSY,
  output logic [3:0]           ST
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LATCH      = 4'd1,
    S_LAUNCH     = 4'd2,
    S_WAIT_START = 4'd3,
    S_WAIT_END   = 4'd4,
    S_CHECK      = 4'd5,
    S_RETRY_GAP  = 4'd6,
    S_DONE       = 4'd7,
    S_GAP        = 4'd8
  } state_t;

  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
  localparam logic [7:0]  RETRY_LIM = 8'(MAX_RETRY);

  state_t       r_state, w_next;
  logic [1:0]   r_winner, r_rr_ptr, w_pick;
  logic         w_any;
  logic [7:0]   r_retry;
  logic [31:0]  r_timer, r_gap_cnt;
  logic         r_err, r_ack;
  logic [15:0]  r_cap_data, r_rdata;
  logic [N_REQ-1:0] r_gnt;
  logic         r_eng_rw;
  logic [7:0]   r_eng_addr, r_eng_ptr;
  logic [15:0]  r_eng_wdata;
  logic         w_timeout, w_gap_done;

  // Requester buses padded to the 4-requester maximum so a 2-bit index selects exactly.
  logic [3:0]   w_req_pad, w_rw_pad, w_onehot;
  logic [31:0]  w_addr_pad, w_ptr_pad;
  logic [63:0]  w_wdata_pad;

  assign w_req_pad   = 4'(REQ);
  assign w_rw_pad    = 4'(REQ_RW);
  assign w_addr_pad  = 32'(REQ_SLAVE_ADDR);
  assign w_ptr_pad   = 32'(REQ_POINTER);
  assign w_wdata_pad = 64'(REQ_WDATA);
  assign w_onehot    = 4'b0001 << r_winner;

  function automatic logic [1:0] wrap_idx(input logic [1:0] base, input int off);
    logic [2:0] s;
    s = {1'b0, base} + 3'(off);
    if (s >= 3'(N_REQ)) s = s - 3'(N_REQ);
    return s[1:0];
  endfunction

  // Descending scan so the lowest offset from the pointer wins.
  always_comb begin
    w_pick = r_rr_ptr;
    w_any  = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_req_pad[wrap_idx(r_rr_ptr, i)]) begin
        w_pick = wrap_idx(r_rr_ptr, i);
        w_any  = 1'b1;
      end
    end
  end

  assign w_timeout  = (r_timer >= TO_LAST);
  assign w_gap_done = (r_gap_cnt >= GAP_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (w_any) w_next = S_LATCH;
      S_LATCH:      w_next = S_LAUNCH;
      S_LAUNCH:     w_next = S_WAIT_START;
      S_WAIT_START: if (!ENG_END) w_next = S_WAIT_END;
                    else if (w_timeout) w_next = S_DONE;
      S_WAIT_END:   if (ENG_END) w_next = S_CHECK;
                    else if (w_timeout) w_next = S_DONE;
      S_CHECK:      if (r_ack) w_next = S_DONE;
                    else if (r_retry < RETRY_LIM) w_next = S_RETRY_GAP;
                    else w_next = S_DONE;
      S_RETRY_GAP:  if (w_gap_done) w_next = S_LAUNCH;
      S_DONE:       w_next = S_GAP;
      S_GAP:        if (w_gap_done) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_winner    <= '0;
      r_rr_ptr    <= '0;
      r_retry     <= '0;
      r_timer     <= '0;
      r_gap_cnt   <= '0;
      r_err       <= 1'b0;
      r_ack       <= 1'b0;
      r_cap_data  <= '0;
      r_rdata     <= '0;
      r_gnt       <= '0;
      r_eng_rw    <= 1'b0;
      r_eng_addr  <= '0;
      r_eng_ptr   <= '0;
      r_eng_wdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (w_any) r_winner <= w_pick;
        S_LATCH: begin
          r_eng_rw    <= w_rw_pad[r_winner];
          r_eng_addr  <= w_addr_pad[{r_winner, 3'b000} +: 8];
          r_eng_ptr   <= w_ptr_pad[{r_winner, 3'b000} +: 8];
          r_eng_wdata <= w_wdata_pad[{r_winner, 4'b0000} +: 16];
          r_gnt       <= w_onehot[N_REQ-1:0];
          r_retry     <= '0;
          r_rr_ptr    <= wrap_idx(r_winner, 1);
        end
        S_LAUNCH: r_timer <= '0;
        S_WAIT_START: begin
          if (!ENG_END) r_timer <= '0;
          else if (w_timeout) r_err <= 1'b1;
          else if (r_timer != '1) r_timer <= r_timer + 32'd1;
        end
        S_WAIT_END: begin
          if (ENG_END) begin
            r_ack      <= ENG_ACK_OK;
            r_cap_data <= ENG_RDATA;
          end else if (w_timeout) r_err <= 1'b1;
          else if (r_timer != '1) r_timer <= r_timer + 32'd1;
        end
        S_CHECK: begin
          r_gap_cnt <= '0;
          if (r_ack) begin
            if (r_eng_rw) r_rdata <= r_cap_data;
          end else if (r_retry < RETRY_LIM) r_retry <= r_retry + 8'd1;
          else r_err <= 1'b1;
        end
        S_RETRY_GAP, S_GAP: if (r_gap_cnt != '1) r_gap_cnt <= r_gap_cnt + 32'd1;
        S_DONE: begin
          r_gnt     <= '0;
          r_err     <= 1'b0;
          r_gap_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign GNT            = r_gnt;
  assign REQ_DONE       = (r_state == S_DONE) ? r_gnt : '0;
  assign REQ_ERR        = (r_state == S_DONE) & r_err;
  assign RDATA          = r_rdata;
  assign ENG_GO         = (r_state == S_LAUNCH);
  assign ENG_RW         = r_eng_rw;
  assign ENG_SLAVE_ADDR = r_eng_addr;
  assign ENG_POINTER    = r_eng_ptr;
  assign ENG_WDATA      = r_eng_wdata;
  assign BUSY           = (r_state != S_IDLE);
  assign ST             = r_state;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb/tb_i2c_bus_arbiter.sv - directed scoreboard bench for i2c_bus_arbiter
module tb_i2c_bus_arbiter;
  localparam int GAP = 8;
  localparam int TO  = 100;

  logic        CLK_50, RESET_N;
  logic [1:0]  REQ, REQ_RW, GNT, REQ_DONE;
  logic [15:0] REQ_SLAVE_ADDR, REQ_POINTER, RDATA, ENG_WDATA, eng_rdata;
  logic [31:0] REQ_WDATA;
  logic        REQ_ERR, ENG_GO, ENG_RW, BUSY, eng_end, eng_ack;
  logic [7:0]  ENG_SLAVE_ADDR, ENG_POINTER;
  logic [3:0]  ST;

  i2c_bus_arbiter #(.N_REQ(2), .GAP_CYCLES(GAP), .MAX_RETRY(3), .TIMEOUT_CYCLES(TO)) dut (
    .CLK_50(CLK_50), .RESET_N(RESET_N), .REQ(REQ), .REQ_RW(REQ_RW),
    .REQ_SLAVE_ADDR(REQ_SLAVE_ADDR), .REQ_POINTER(REQ_POINTER), .REQ_WDATA(REQ_WDATA),
    .GNT(GNT), .REQ_DONE(REQ_DONE), .REQ_ERR(REQ_ERR), .RDATA(RDATA),
    .ENG_GO(ENG_GO), .ENG_RW(ENG_RW), .ENG_SLAVE_ADDR(ENG_SLAVE_ADDR),
    .ENG_POINTER(ENG_POINTER), .ENG_WDATA(ENG_WDATA), .ENG_END(eng_end),
    .ENG_ACK_OK(eng_ack), .ENG_RDATA(eng_rdata), .BUSY(BUSY), .ST(ST)
  );

  typedef struct { int idx; logic err; logic [15:0] rdata; } exp_t;
  exp_t sb[$];
  int   go_q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, rise_cyc = 0;
  int   eng_mode = 0, nack_first = 0, eng_attempt = 0;
  logic [15:0] rd_val = 16'h0;

  initial CLK_50 = 1'b0;
  always #10 CLK_50 = ~CLK_50;
  always @(posedge CLK_50) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and per-cycle invariants.
  always @(negedge CLK_50) begin
    exp_t e;
    logic [1:0] ev;
    if (ENG_GO) go_q.push_back(cyc);
    if (ST == 4'd8) chk("gnt_in_gap", 32'(GNT), 32'd0);
    if (GNT != 2'b00) chk("gnt_onehot", 32'($onehot(GNT)), 32'd1);
    if (RESET_N && REQ_DONE != 2'b00) begin
      chk("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e  = sb.pop_front();
        ev = 2'(1 << e.idx);
        chk("done_vec", 32'(REQ_DONE), 32'(ev));
        chk("done_err", 32'(REQ_ERR), 32'(e.err));
        chk("done_rdata", 32'(RDATA), 32'(e.rdata));
      end
    end
  end

  // Engine model: mode 0 normal, 1 never leaves idle, 2 stuck busy.
  initial begin
    eng_end = 1'b1; eng_ack = 1'b0; eng_rdata = 16'h0;
    forever begin
      @(posedge CLK_50); #1;
      if (ENG_GO) begin
        eng_attempt++;
        if (eng_mode == 0) begin
          eng_end = 1'b0;
          repeat (4) @(posedge CLK_50);
          #1;
          eng_ack   = (eng_attempt > nack_first);
          eng_rdata = rd_val;
          eng_end   = 1'b1;
          rise_cyc  = cyc;
        end else if (eng_mode == 2) begin
          eng_end = 1'b0;
          for (int i = 0; i < 300; i++) begin
            @(posedge CLK_50); #1;
            if (REQ_DONE != 2'b00 || !BUSY) break;
          end
          eng_end = 1'b1;
        end
      end
    end
  end

  initial begin
    #1_900_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  task automatic wait_go(output int gc);
    gc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK_50);
      if (ENG_GO) begin gc = cyc; break; end
    end
    if (gc < 0) chk("wait_go_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(output int idx, output int dc);
    idx = -1; dc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK_50);
      if (REQ_DONE != 2'b00) begin idx = REQ_DONE[1] ? 1 : 0; dc = cyc; break; end
    end
    if (dc < 0) chk("wait_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_state(input logic [3:0] s);
    bit hit = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK_50);
      if (ST == s) begin hit = 1; break; end
    end
    if (!hit) chk("wait_state_timeout", 32'(ST), 32'(s));
  endtask

  task automatic do_reset();
    @(posedge CLK_50); #1; RESET_N = 1'b0; REQ = 2'b00;
    @(posedge CLK_50); #1; RESET_N = 1'b1;
  endtask

  task automatic single(input int r, input int exp_gap_min, input int exp_gos);
    int idx, dc;
    go_q.delete();
    @(posedge CLK_50); #1; REQ[r] = 1'b1;
    wait_done(idx, dc);
    @(posedge CLK_50); #1; REQ[r] = 1'b0;
    chk("go_count", 32'(go_q.size()), 32'(exp_gos));
    for (int i = 1; i < go_q.size(); i++)
      chk("retry_spacing", 32'(go_q[i] - go_q[i-1] >= exp_gap_min), 32'd1);
    wait_state(4'd0);
  endtask

  initial begin
    int rc, gc, dc, idx;
    RESET_N = 1'b0; REQ = 2'b00; REQ_RW = 2'b00;
    REQ_SLAVE_ADDR = 16'h0; REQ_POINTER = 16'h0; REQ_WDATA = 32'h0;
    repeat (3) @(posedge CLK_50);
    @(negedge CLK_50);
    chk("rst_st", 32'(ST), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_gnt", 32'(GNT), 32'd0);
    chk("rst_done", 32'(REQ_DONE), 32'd0);
    chk("rst_go", 32'(ENG_GO), 32'd0);
    chk("rst_wdata", 32'(ENG_WDATA), 32'd0);
    @(posedge CLK_50); #1; RESET_N = 1'b1;

    // Single write on requester 0
    REQ_SLAVE_ADDR[7:0] = 8'h18; REQ_POINTER[7:0] = 8'h3A; REQ_WDATA[15:0] = 16'h1234;
    sb.push_back('{0, 1'b0, 16'h0});
    go_q.delete();
    @(posedge CLK_50); #1; REQ[0] = 1'b1; rc = cyc;
    wait_go(gc);
    chk("go_latency", 32'(gc - rc), 32'd2);
    chk("eng_addr", 32'(ENG_SLAVE_ADDR), 32'h18);
    chk("eng_ptr", 32'(ENG_POINTER), 32'h3A);
    chk("eng_wdata", 32'(ENG_WDATA), 32'h1234);
    chk("eng_rw", 32'(ENG_RW), 32'd0);
    chk("gnt0", 32'(GNT), 32'd1);
    REQ_SLAVE_ADDR[7:0] = 8'h55;
    wait_done(idx, dc);
    chk("eng_addr_held", 32'(ENG_SLAVE_ADDR), 32'h18);
    @(posedge CLK_50); #1; REQ[0] = 1'b0;
    chk("single_go_count", 32'(go_q.size()), 32'd1);
    wait_state(4'd0);
    chk("busy_fall", 32'(cyc - dc), 32'(GAP + 1));

    // Round robin from reset: 0,1,0,1
    do_reset();
    REQ_SLAVE_ADDR = 16'h3020;
    for (int k = 0; k < 4; k++) sb.push_back('{k % 2, 1'b0, 16'h0});
    @(posedge CLK_50); #1; REQ = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_done(idx, dc);
      if (idx < 0) break;
      @(posedge CLK_50); #1; REQ[idx] = 1'b0;
      if (k < 2) begin @(posedge CLK_50); #1; REQ[idx] = 1'b1; end
    end
    REQ = 2'b00;
    wait_state(4'd0);

    // Read on requester 1
    REQ_RW[1] = 1'b1; rd_val = 16'hBEEF;
    sb.push_back('{1, 1'b0, 16'hBEEF});
    @(posedge CLK_50); #1; REQ[1] = 1'b1;
    wait_done(idx, dc);
    chk("end_to_done", 32'(dc - rise_cyc), 32'd2);
    @(posedge CLK_50); #1; REQ[1] = 1'b0;
    wait_state(4'd0);

    // NACK on every attempt, then NACK followed by ACK
    nack_first = 100; eng_attempt = 0; rd_val = 16'h1111;
    sb.push_back('{0, 1'b1, 16'hBEEF});
    single(0, GAP, 4);
    nack_first = 1; eng_attempt = 0;
    sb.push_back('{0, 1'b0, 16'hBEEF});
    single(0, GAP, 2);

    // Watchdog: engine never starts, then engine never finishes
    eng_mode = 1;
    sb.push_back('{0, 1'b1, 16'hBEEF});
    @(posedge CLK_50); #1; REQ[0] = 1'b1;
    wait_go(gc); wait_done(idx, dc);
    chk("timeout_start", 32'(dc - gc), 32'(TO + 1));
    @(posedge CLK_50); #1; REQ[0] = 1'b0;
    wait_state(4'd0);
    eng_mode = 2;
    sb.push_back('{0, 1'b1, 16'hBEEF});
    @(posedge CLK_50); #1; REQ[0] = 1'b1;
    wait_go(gc); wait_done(idx, dc);
    chk("timeout_end", 32'(dc - gc), 32'(TO + 2));
    @(posedge CLK_50); #1; REQ[0] = 1'b0;
    wait_state(4'd0);

    // Reset during WAIT_END abandons the transaction
    @(posedge CLK_50); #1; REQ[0] = 1'b1;
    wait_state(4'd4);
    go_q.delete();
    @(posedge CLK_50); #1; RESET_N = 1'b0; REQ = 2'b00;
    @(posedge CLK_50); #1; RESET_N = 1'b1;
    @(negedge CLK_50);
    chk("mid_rst_gnt", 32'(GNT), 32'd0);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    chk("mid_rst_st", 32'(ST), 32'd0);
    chk("mid_rst_rdata", 32'(RDATA), 32'd0);
    chk("mid_rst_addr", 32'(ENG_SLAVE_ADDR), 32'd0);
    eng_mode = 0;
    repeat (20) @(negedge CLK_50);
    chk("mid_rst_no_go", 32'(go_q.size()), 32'd0);
    REQ_RW = 2'b00;
    sb.push_back('{0, 1'b0, 16'h0});
    sb.push_back('{1, 1'b0, 16'h0});
    @(posedge CLK_50); #1; REQ = 2'b11;
    for (int k = 0; k < 2; k++) begin
      wait_done(idx, dc);
      if (idx < 0) break;
      @(posedge CLK_50); #1; REQ[idx] = 1'b0;
    end
    REQ = 2'b00;
    wait_state(4'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one I2C transaction engine (write-word / read-data master, 400 kHz SCL) between N_REQ requesters, e.g. VCM autofocus writes and sensor register config.
- Arbitrates round-robin, latches the winner's transaction fields and launches the engine.
- Monitors engine completion, retries on NACK, enforces a watchdog timeout and a minimum inter-transaction bus gap.
- Sits between the requester control FSMs and the engine, in place of per-requester hard-wired GO logic.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- GAP_CYCLES, 1000, idle CLK_50 cycles enforced after every transaction before the next grant.
- MAX_RETRY, 3, extra attempts after a NACK before reporting an error.
- TIMEOUT_CYCLES, 250000, watchdog limit for engine start or engine end, in CLK_50 cycles.

Ports:
- CLK_50  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  synchronous active-low reset.
- REQ  in  N_REQ  per-requester request level; held until the matching REQ_DONE.
- REQ_RW  in  N_REQ  1 = read, 0 = write.
- REQ_SLAVE_ADDR  in  8*N_REQ  7-bit address plus R/W bit field; requester i uses [8i+7:8i].
- REQ_POINTER  in  8*N_REQ  register pointer per requester.
- REQ_WDATA  in  16*N_REQ  write data per requester.
- GNT  out  N_REQ  one-hot; high from latch until done.
- REQ_DONE  out  N_REQ  one-cycle completion pulse to the granted requester.
- REQ_ERR  out  1  qualifies REQ_DONE: 1 = failed (NACK exhausted or timeout).
- RDATA  out  16  read result; valid with REQ_DONE for read transactions.
- ENG_GO  out  1  one-cycle start pulse to the engine.
- ENG_RW  out  1  latched transaction direction.
- ENG_SLAVE_ADDR  out  8  latched slave address.
- ENG_POINTER  out  8  latched register pointer.
- ENG_WDATA  out  16  latched write data.
- ENG_END  in  1  engine idle/finished level (low while busy).
- ENG_ACK_OK  in  1  all ACKs received; sampled when ENG_END rises.
- ENG_RDATA  in  16  engine read data; sampled when ENG_END rises.
- BUSY  out  1  high in every state except IDLE.
- ST  out  4  current state encoding, for debug.

Behaviour:
- Reset values (RESET_N low at a clock edge):
  - State IDLE; all outputs 0; round-robin pointer = 0; counters cleared.
  - Reset mid-transaction abandons it: no REQ_DONE is issued and ENG_GO stays 0.
- IDLE(0): if any REQ bit is set, pick the first set bit at or after rr_ptr, wrapping. Register the winner index; go to LATCH.
- LATCH(1):
  - Copy the winner's fields to the ENG_* outputs and set GNT[winner].
  - Clear the retry counter; set rr_ptr = winner+1 mod N_REQ; go to LAUNCH.
  - The latched fields are stable until DONE regardless of later requester input changes.
- LAUNCH(2): ENG_GO = 1 for exactly this cycle; clear the timer; go to WAIT_START.
- WAIT_START(3):
  - ENG_END low → clear the timer, go to WAIT_END.
  - Timer reaches TIMEOUT_CYCLES-1 → set the error flag, go to DONE.
- WAIT_END(4):
  - ENG_END high → capture ENG_ACK_OK and ENG_RDATA, go to CHECK.
  - Same timeout rule as WAIT_START.
- CHECK(5):
  - ACK ok → DONE.
  - NACK and retry count < MAX_RETRY → increment the count, go to RETRY_GAP.
  - NACK and retries exhausted → set the error flag, go to DONE.
- RETRY_GAP(6): wait GAP_CYCLES, then go to LAUNCH with the same latched fields.
- DONE(7):
  - Pulse REQ_DONE[winner] for one cycle; REQ_ERR = error flag; RDATA = captured data.
  - RDATA updates only on a successful read; otherwise it holds its previous value.
  - Clear GNT and the error flag; go to GAP.
- GAP(8): count GAP_CYCLES; then go to IDLE.
  - REQ bits asserted during GAP wait; no grant is issued before GAP ends.
- Latency:
  - IDLE→ENG_GO is 2 cycles.
  - ENG_END rise → REQ_DONE is 2 cycles (WAIT_END→CHECK→DONE).
- Simultaneous requests are resolved by the rotating pointer, so there is no starvation.
- A requester dropping REQ after its grant does not abort the transaction; the result is still reported.
- Timer and gap counters are 32 bit and saturate; GAP_CYCLES = 0 means a 1-cycle pass-through.
- ENG_END already high at WAIT_START with no falling edge leads to a timeout error, not false completion.

Test Plan:
- Single write on requester 0 (addr 0x18, ptr 0x3A, data 0x1234), engine ACK ok → ENG_GO exactly once, 2 cycles after REQ; ENG_* = 0x18/0x3A/0x1234; REQ_DONE[0] pulses with REQ_ERR = 0; BUSY falls GAP_CYCLES+1 cycles after DONE.
- REQ[0] and REQ[1] asserted together from reset, each re-raised after done → grant order 0,1,0,1; no grant inside GAP; each GNT is one-hot.
- Read on requester 1, engine returns 0xBEEF with ACK → RDATA = 0xBEEF coincident with REQ_DONE[1], REQ_ERR = 0.
- Engine NACKs every attempt with MAX_RETRY = 3 → 4 ENG_GO pulses, each separated by ≥ GAP_CYCLES; final REQ_DONE with REQ_ERR = 1; RDATA unchanged. Variant: NACK then ACK → 2 pulses, REQ_ERR = 0.
- Engine never drops ENG_END (TIMEOUT_CYCLES = 100) → REQ_DONE with REQ_ERR = 1 exactly 100 cycles into WAIT_START. Repeat with ENG_END stuck low in WAIT_END → same result.
- RESET_N low for 1 cycle during WAIT_END → all outputs 0 next cycle; no REQ_DONE; a fresh request afterwards is granted from rr_ptr = 0.
